// File: rtl/axi_cmd_master.sv
// Single-outstanding AXI4 initiator: one command becomes one single-beat AXI read or write,
// and the outcome is returned on a valid/ready response port.
//
// state   | meaning
// --------+---------------------------------------------------------
// IDLE    | req_ready high, waiting for a command
// RD_ADDR | arvalid presented, waiting for arready
// RD_DATA | rready high, waiting for rvalid or timeout
// WR_REQ  | awvalid/wvalid presented, each drops after its own handshake
// WR_RESP | bready high, waiting for bvalid or timeout
// RSP     | resp_valid held until resp_ready
module axi_cmd_master #(
    parameter int TAGW    = 1,
    parameter int TIMEOUT = 1024
) (
    input  logic            aclk,
    input  logic            rst_l,

    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_write,
    input  logic [31:0]     req_addr,
    input  logic [63:0]     req_wdata,
    input  logic [7:0]      req_wstrb,

    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [63:0]     resp_rdata,
    output logic [1:0]      resp_err,

    output logic            arvalid,
    input  logic            arready,
    output logic [31:0]     araddr,
    output logic [TAGW-1:0] arid,
    output logic [7:0]      arlen,
    output logic [1:0]      arburst,
    output logic [2:0]      arsize,

    input  logic            rvalid,
    output logic            rready,
    input  logic [63:0]     rdata,
    input  logic [1:0]      rresp,
    input  logic [TAGW-1:0] rid,
    input  logic            rlast,

    output logic            awvalid,
    input  logic            awready,
    output logic [31:0]     awaddr,
    output logic [TAGW-1:0] awid,
    output logic [7:0]      awlen,
    output logic [1:0]      awburst,
    output logic [2:0]      awsize,

    output logic            wvalid,
    input  logic            wready,
    output logic [63:0]     wdata,
    output logic [7:0]      wstrb,
    output logic            wlast,

    input  logic            bvalid,
    output logic            bready,
    input  logic [1:0]      bresp,
    input  logic [TAGW-1:0] bid
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] TMO_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, RSP} state_t;

    state_t          state;
    logic [TAGW-1:0] tag_cnt;
    logic [TAGW-1:0] id_q;
    logic [31:0]     addr_q;
    logic [CW-1:0]   tmo_cnt;
    logic            tmo_hit;

    assign tmo_hit = (TIMEOUT != 0) && (tmo_cnt == TMO_LAST);

    assign araddr  = addr_q;
    assign awaddr  = addr_q;
    assign arid    = id_q;
    assign awid    = id_q;
    assign arlen   = 8'd0;
    assign awlen   = 8'd0;
    assign arsize  = 3'd3;
    assign awsize  = 3'd3;
    assign arburst = 2'b01;
    assign awburst = 2'b01;
    assign wlast   = 1'b1;

    always_ff @(posedge aclk or negedge rst_l) begin
        if (!rst_l) begin
            state      <= IDLE;
            req_ready  <= 1'b0;
            resp_valid <= 1'b0;
            resp_rdata <= 64'd0;
            resp_err   <= 2'b00;
            arvalid    <= 1'b0;
            rready     <= 1'b0;
            awvalid    <= 1'b0;
            wvalid     <= 1'b0;
            bready     <= 1'b0;
            wdata      <= 64'd0;
            wstrb      <= 8'd0;
            addr_q     <= 32'd0;
            id_q       <= '0;
            tag_cnt    <= '0;
            tmo_cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    req_ready <= 1'b1;
                    if (req_valid && req_ready) begin
                        req_ready <= 1'b0;
                        addr_q    <= req_addr;
                        wdata     <= req_wdata;
                        wstrb     <= req_wstrb;
                        id_q      <= tag_cnt;
                        tag_cnt   <= tag_cnt + TAGW'(1);
                        if (req_write) begin
                            awvalid <= 1'b1;
                            wvalid  <= 1'b1;
                            state   <= WR_REQ;
                        end else begin
                            arvalid <= 1'b1;
                            state   <= RD_ADDR;
                        end
                    end
                end
                RD_ADDR: begin
                    if (arready) begin
                        arvalid <= 1'b0;
                        rready  <= 1'b1;
                        tmo_cnt <= '0;
                        state   <= RD_DATA;
                    end
                end
                RD_DATA: begin
                    if (rvalid) begin
                        rready     <= 1'b0;
                        resp_valid <= 1'b1;
                        resp_rdata <= rdata;
                        if (rid != id_q)
                            resp_err <= 2'b10;
                        else if (rresp != 2'b00 || !rlast)
                            resp_err <= 2'b01;
                        else
                            resp_err <= 2'b00;
                        state <= RSP;
                    end else if (tmo_hit) begin
                        rready     <= 1'b0;
                        resp_valid <= 1'b1;
                        resp_rdata <= 64'd0;
                        resp_err   <= 2'b11;
                        state      <= RSP;
                    end else begin
                        tmo_cnt <= tmo_cnt + CW'(1);
                    end
                end
                WR_REQ: begin
                    // A lowered valid doubles as the "channel done" flag.
                    if (awready) awvalid <= 1'b0;
                    if (wready)  wvalid  <= 1'b0;
                    if ((!awvalid || awready) && (!wvalid || wready)) begin
                        bready  <= 1'b1;
                        tmo_cnt <= '0;
                        state   <= WR_RESP;
                    end
                end
                WR_RESP: begin
                    if (bvalid) begin
                        bready     <= 1'b0;
                        resp_valid <= 1'b1;
                        resp_rdata <= 64'd0;
                        if (bid != id_q)
                            resp_err <= 2'b10;
                        else if (bresp != 2'b00)
                            resp_err <= 2'b01;
                        else
                            resp_err <= 2'b00;
                        state <= RSP;
                    end else if (tmo_hit) begin
                        bready     <= 1'b0;
                        resp_valid <= 1'b1;
                        resp_rdata <= 64'd0;
                        resp_err   <= 2'b11;
                        state      <= RSP;
                    end else begin
                        tmo_cnt <= tmo_cnt + CW'(1);
                    end
                end
                RSP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        req_ready  <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/axi_cmd_master.md
Name: axi_cmd_master

Overview:
- Single-outstanding AXI4 initiator.
- Converts a simple valid/ready command port (one 64-bit read or write per command) into single-beat AXI4 AR/R or AW/W/B transactions.
- Returns a response record on a valid/ready response port.
- Used by testbench loaders and bus-traffic drivers to exercise the platform's AXI4 responders, including the memory/mailbox/UART model.

Parameters:
- TAGW, 1, width of arid/awid/rid/bid.
- TIMEOUT, 1024, cycles to wait for R or B before aborting; 0 disables the timeout.

Ports:
- aclk  in  1  clock
- rst_l  in  1  reset
- req_valid  in  1  command valid
- req_ready  out  1  command accepted when valid&&ready
- req_write  in  1  1=write, 0=read
- req_addr  in  32  byte address
- req_wdata  in  64  write data
- req_wstrb  in  8  write byte strobes
- resp_valid  out  1  response valid
- resp_ready  in  1  response consumed
- resp_rdata  out  64  read data (0 for writes/timeouts)
- resp_err  out  2  00 OK, 01 AXI error, 10 ID mismatch, 11 timeout
- arvalid/arready  out/in  1/1  read address handshake
- araddr, arid, arlen, arburst, arsize  out  32, TAGW, 8, 2, 3
- rvalid/rready  in/out  1/1; rdata in 64; rresp in 2; rid in TAGW; rlast in 1
- awvalid/awready  out/in  1/1; awaddr, awid, awlen, awburst, awsize  out  32, TAGW, 8, 2, 3
- wvalid/wready  out/in  1/1; wdata out 64; wstrb out 8; wlast out 1
- bvalid/bready  in/out  1/1; bresp in 2; bid in TAGW

Behaviour:
- Reset: asynchronous, active-low rst_l; clock aclk (both already decided). Reset asserted at any time, including mid-transaction, aborts the transaction immediately.
- Reset values:
  - All valids/readies driven by this block are 0; req_ready is 0 while rst_l is low.
  - resp_rdata=0, resp_err=0, tag counter=0, timeout counter=0, state=IDLE.
- Constants: arlen=awlen=0, arsize=awsize=3, arburst=awburst=2'b01, wlast=1.
- Address/ID/data outputs are registered at acceptance and held stable while their valid is high.
- States: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, RSP.
- IDLE:
  - req_ready=1.
  - On req_valid: latch the command, assign id=tag counter, increment tag counter (wraps mod 2^TAGW).
  - Next state is WR_REQ if req_write, else RD_ADDR.
- RD_ADDR:
  - arvalid=1 from the first cycle after acceptance and held until arready.
  - On the arready cycle, go to RD_DATA.
- RD_DATA:
  - rready=1.
  - On rvalid: capture rdata and go to RSP.
  - Error priority: rid!=id gives 10; else rresp!=0 or rlast==0 gives 01; else 00.
- WR_REQ:
  - awvalid=1 and wvalid=1 from the first cycle after acceptance.
  - Each valid drops independently after its own handshake; pending flags track AW done and W done.
  - Go to WR_RESP once both are done, including when both complete in the same cycle.
  - Never re-present a completed channel.
- WR_RESP:
  - bready=1.
  - On bvalid: go to RSP. Error priority: bid!=id gives 10; else bresp!=0 gives 01.
  - resp_rdata=0.
- Timeout:
  - Counter clears on entry to RD_DATA/WR_RESP and increments each cycle without the handshake.
  - When it reaches TIMEOUT (if nonzero): go to RSP with err=11 and rdata=0, and deassert rready/bready.
  - A late R/B after a timeout is not accepted; rready/bready stay 0 outside RD_DATA/WR_RESP.
  - AR/AW/W waits have no timeout.
- RSP:
  - resp_valid=1 with rdata/err stable until resp_ready, then IDLE.
  - req_ready=0 until back in IDLE; no command overlap.
- Latency, zero-wait responder:
  - Read: accept at cycle 0, arvalid at 1, rvalid at 2, resp_valid at 3.
  - Write: same shape, with bvalid at 2.
- Outputs to AXI are driven from registers; no combinational path from the AXI inputs to the AXI valid outputs.

Test Plan:
- Write addr 0x1000, data 0x1122334455667788, wstrb 0xFF; then read 0x1000 with a zero-wait responder -> read response rdata=0x1122334455667788, err=00, resp_valid at cycle 3 after accept; ids 0 then 1 (TAGW=1).
- awready delayed 3 cycles, wready immediate (and vice versa; and both same cycle) -> wvalid drops after its own handshake, single AW and single W beat, bready only after both are done.
- resp_ready held low 5 cycles -> resp_valid, resp_rdata, resp_err stable; req_ready=0 throughout; next command is accepted only after the consume.
- bresp=2'b10 on a write -> err=01; rid returned as ~arid on a read -> err=10 (takes priority even with rresp=2'b10).
- TIMEOUT=16, responder never asserts rvalid -> resp_valid 16 cycles after entering RD_DATA, err=11, rdata=0, rready low afterwards.
- TAGW=2, 5 back-to-back reads -> arid sequence 0,1,2,3,0; rst_l pulsed while awvalid is high -> awvalid/wvalid drop asynchronously, tag counter=0, state IDLE.
